// File: rtl/branch_predictor.sv
// Branch prediction unit: untagged saturating-counter BHT, tagged BTB with per-entry type and a
// non-speculative return address stack. Lookup is combinational in IF, training comes from EX.
module branch_predictor #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned TAG_BITS  = 8,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_pc,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_is_branch,
    input  logic                upd_is_call,
    input  logic                upd_is_ret,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target
);

    localparam int unsigned IdxBits    = $clog2(ENTRIES);
    localparam int unsigned PtrBits    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RasCntBits = $clog2(RAS_DEPTH + 1);

    localparam logic [CNT_BITS-1:0]   CntInit = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]   CntMax  = '1;
    localparam logic [PtrBits-1:0]    PtrLast = PtrBits'(RAS_DEPTH - 1);
    localparam logic [RasCntBits-1:0] RasFull = RasCntBits'(RAS_DEPTH);
    localparam logic [RasCntBits-1:0] RasOne  = RasCntBits'(1);
    localparam logic [PC_WIDTH-1:0]   PcStep  = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        TypeBranch = 2'd0,
        TypeJump   = 2'd1,
        TypeRet    = 2'd2
    } btb_type_e;

    // BTB and BHT storage
    logic [ENTRIES-1:0]  btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] btb_target_q [ENTRIES];
    btb_type_e           btb_type_q   [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q        [ENTRIES];

    // Return address stack: circular storage with a top pointer and an occupancy count
    logic [PC_WIDTH-1:0]   ras_q [RAS_DEPTH];
    logic [PtrBits-1:0]    ras_ptr_q, ras_ptr_d;
    logic [RasCntBits-1:0] ras_cnt_q, ras_cnt_d;

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [IdxBits-1:0]  if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic                hit;
    logic                lookup_taken;
    logic                use_ras;
    logic [PC_WIDTH-1:0] seq_pc;

    assign if_idx = if_pc[IdxBits+1:2];
    assign if_tag = if_pc[IdxBits+TAG_BITS+1:IdxBits+2];

    always_comb begin
        seq_pc       = if_pc + PcStep;
        hit          = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
        lookup_taken = hit && ((btb_type_q[if_idx] != TypeBranch) ||
                               cnt_q[if_idx][CNT_BITS-1]);
        use_ras      = (btb_type_q[if_idx] == TypeRet) && (ras_cnt_q != '0);
        pred_taken   = lookup_taken && !areset;
        if (!pred_taken) begin
            pred_pc = seq_pc;
        end else if (use_ras) begin
            pred_pc = ras_q[ras_ptr_q];
        end else begin
            pred_pc = btb_target_q[if_idx];
        end
    end

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    logic [IdxBits-1:0]  upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                bht_we;
    logic                btb_we;
    logic                ras_push;
    logic                ras_pop;
    logic                ras_swap;
    btb_type_e           upd_type;

    assign upd_idx  = upd_pc[IdxBits+1:2];
    assign upd_tag  = upd_pc[IdxBits+TAG_BITS+1:IdxBits+2];
    assign bht_we   = upd_valid && upd_is_branch;
    assign btb_we   = upd_valid && upd_taken;
    assign ras_push = upd_valid && upd_is_call && !upd_is_ret;
    assign ras_pop  = upd_valid && upd_is_ret && !upd_is_call;
    assign ras_swap = upd_valid && upd_is_call && upd_is_ret;

    always_comb begin
        if (upd_is_ret) begin
            upd_type = TypeRet;
        end else if (upd_is_branch) begin
            upd_type = TypeBranch;
        end else begin
            upd_type = TypeJump;
        end
    end

    // Saturating counter step for the entry being trained
    logic [CNT_BITS-1:0] cnt_cur;
    logic [CNT_BITS-1:0] cnt_next;

    always_comb begin
        cnt_cur  = cnt_q[upd_idx];
        cnt_next = cnt_cur;
        if (upd_taken) begin
            if (cnt_cur != CntMax) begin
                cnt_next = cnt_cur + 1'b1;
            end
        end else if (cnt_cur != '0) begin
            cnt_next = cnt_cur - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RAS next state
    // ------------------------------------------------------------------
    logic [PtrBits-1:0]  ptr_inc;
    logic [PtrBits-1:0]  ptr_dec;
    logic                ras_we;
    logic [PtrBits-1:0]  ras_wr_ptr;
    logic [PC_WIDTH-1:0] ras_wdata;

    assign ras_wdata = upd_pc + PcStep;

    always_comb begin
        ptr_inc    = (ras_ptr_q == PtrLast) ? '0 : ras_ptr_q + 1'b1;
        ptr_dec    = (ras_ptr_q == '0) ? PtrLast : ras_ptr_q - 1'b1;
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_we     = 1'b0;
        ras_wr_ptr = ras_ptr_q;
        if (ras_push) begin
            // A full stack keeps its count; the new top lands on the oldest slot
            ras_ptr_d  = ptr_inc;
            ras_wr_ptr = ptr_inc;
            ras_we     = 1'b1;
            if (ras_cnt_q != RasFull) begin
                ras_cnt_d = ras_cnt_q + 1'b1;
            end
        end else if (ras_pop) begin
            if (ras_cnt_q != '0) begin
                ras_ptr_d = ptr_dec;
                ras_cnt_d = ras_cnt_q - 1'b1;
            end
        end else if (ras_swap) begin
            ras_we = 1'b1;
            if (ras_cnt_q == '0) begin
                ras_cnt_d = RasOne;
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            btb_valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CntInit;
            end
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            if (btb_we) begin
                btb_valid_q[upd_idx] <= 1'b1;
            end
            if (bht_we) begin
                cnt_q[upd_idx] <= cnt_next;
            end
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Payload arrays are qualified by valid bits and the RAS count, so they carry no reset
    always_ff @(posedge aclk) begin
        if (btb_we && !areset) begin
            btb_tag_q[upd_idx]    <= upd_tag;
            btb_target_q[upd_idx] <= upd_target;
            btb_type_q[upd_idx]   <= upd_type;
        end
        if (ras_we && !areset) begin
            ras_q[ras_wr_ptr] <= ras_wdata;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: two configurations share stimulus and are checked
// every cycle against a behavioural model of the BHT, BTB and return stack.
module tb_branch_predictor;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_call;
    logic        upd_is_ret;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        a_taken;
    logic [31:0] a_pc;
    logic        b_taken;
    logic [31:0] b_pc;

    always #5 aclk = ~aclk;

    branch_predictor dut_a (
        .aclk          (aclk),
        .areset        (areset),
        .if_pc         (if_pc),
        .pred_taken    (a_taken),
        .pred_pc       (a_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_is_branch (upd_is_branch),
        .upd_is_call   (upd_is_call),
        .upd_is_ret    (upd_is_ret),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
    );

    branch_predictor #(
        .PC_WIDTH  (32),
        .ENTRIES   (64),
        .CNT_BITS  (3),
        .TAG_BITS  (4),
        .RAS_DEPTH (4)
    ) dut_b (
        .aclk          (aclk),
        .areset        (areset),
        .if_pc         (if_pc),
        .pred_taken    (b_taken),
        .pred_pc       (b_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_is_branch (upd_is_branch),
        .upd_is_call   (upd_is_call),
        .upd_is_ret    (upd_is_ret),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
    );

    // ---------------- behavioural model ----------------
    localparam int KindBranch = 0;
    localparam int KindJump   = 1;
    localparam int KindRet    = 2;

    typedef struct {
        bit          valid;
        int unsigned tag;
        logic [31:0] target;
        int          kind;
    } btb_ent_t;

    btb_ent_t    m_btb   [2][64];
    int unsigned m_cnt   [2][64];
    logic [31:0] m_ras   [2][4];   // index 0 is the oldest live entry
    int          m_ras_n [2];

    function automatic int unsigned cfg_entries(input int m);
        return (m == 0) ? 16 : 64;
    endfunction

    function automatic int unsigned cfg_cnt_bits(input int m);
        return (m == 0) ? 2 : 3;
    endfunction

    function automatic int unsigned cfg_tag_bits(input int m);
        return (m == 0) ? 8 : 4;
    endfunction

    function automatic int unsigned idx_of(input int m, input logic [31:0] pc);
        return (pc / 4) % cfg_entries(m);
    endfunction

    function automatic int unsigned tag_of(input int m, input logic [31:0] pc);
        return (pc / (4 * cfg_entries(m))) % (1 << cfg_tag_bits(m));
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) begin
                m_btb[m][i].valid = 1'b0;
                m_cnt[m][i] = (1 << (cfg_cnt_bits(m) - 1)) - 1;
            end
            m_ras_n[m] = 0;
        end
    endtask

    task automatic model_lookup(input int m, input logic [31:0] pc, output bit tk,
                                output logic [31:0] np);
        int unsigned i;
        bit hit;
        i   = idx_of(m, pc);
        hit = m_btb[m][i].valid && (m_btb[m][i].tag == tag_of(m, pc));
        tk  = hit && ((m_btb[m][i].kind != KindBranch) ||
                      (m_cnt[m][i] >= (1 << (cfg_cnt_bits(m) - 1))));
        if (tk && m_btb[m][i].kind == KindRet && m_ras_n[m] > 0) np = m_ras[m][m_ras_n[m] - 1];
        else if (tk) np = m_btb[m][i].target;
        else np = pc + 32'd4;
    endtask

    task automatic model_update(input int m);
        int unsigned i;
        int unsigned top;
        if (!upd_valid) return;
        i   = idx_of(m, upd_pc);
        top = (1 << cfg_cnt_bits(m)) - 1;
        if (upd_is_branch) begin
            if (upd_taken) begin
                if (m_cnt[m][i] < top) m_cnt[m][i] = m_cnt[m][i] + 1;
            end else if (m_cnt[m][i] > 0) begin
                m_cnt[m][i] = m_cnt[m][i] - 1;
            end
        end
        if (upd_taken) begin
            m_btb[m][i].valid  = 1'b1;
            m_btb[m][i].tag    = tag_of(m, upd_pc);
            m_btb[m][i].target = upd_target;
            m_btb[m][i].kind   = upd_is_ret ? KindRet : (upd_is_branch ? KindBranch : KindJump);
        end
        if (upd_is_call && !upd_is_ret) begin
            if (m_ras_n[m] == 4) begin
                for (int k = 0; k < 3; k++) m_ras[m][k] = m_ras[m][k + 1];
                m_ras_n[m] = 3;
            end
            m_ras[m][m_ras_n[m]] = upd_pc + 32'd4;
            m_ras_n[m] = m_ras_n[m] + 1;
        end else if (upd_is_ret && !upd_is_call) begin
            if (m_ras_n[m] > 0) m_ras_n[m] = m_ras_n[m] - 1;
        end else if (upd_is_call && upd_is_ret) begin
            if (m_ras_n[m] == 0) m_ras_n[m] = 1;
            m_ras[m][m_ras_n[m] - 1] = upd_pc + 32'd4;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          step;
        int          dut;
        bit          taken;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   look_en = 1'b0;
    int   step_no = 0;

    always @(negedge aclk) begin
        if (look_en) begin
            for (int m = 0; m < 2; m++) begin
                exp_t        e;
                logic        at;
                logic [31:0] ap;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard dut%0d: no expectation queued, want one", m);
                end else begin
                    e  = exp_q.pop_front();
                    at = (e.dut == 0) ? a_taken : b_taken;
                    ap = (e.dut == 0) ? a_pc : b_pc;
                    if (at !== e.taken || ap !== e.pc) begin
                        errors++;
                        $display("FAIL lookup step %0d dut%0d: got taken=%0d pc=0x%08h, want taken=%0d pc=0x%08h",
                                 e.step, e.dut, at, ap, e.taken, e.pc);
                    end
                end
            end
        end
    end

    // One cycle: drive lookup and update, queue the expected lookup (pre-update state), then
    // advance the model as the coming edge will. use_c pins config 0's expectation to a constant.
    task automatic step(input bit rst, input logic [31:0] pc, input bit uv,
                        input logic [31:0] upc, input bit br, input bit call, input bit ret,
                        input bit tk, input logic [31:0] tgt, input bit use_c = 1'b0,
                        input bit c_tk = 1'b0, input logic [31:0] c_pc = 32'd0);
        bit          et;
        logic [31:0] ep;
        @(posedge aclk);
        #1;
        areset = rst;
        if (rst) model_reset();
        if_pc         = pc;
        upd_valid     = uv;
        upd_pc        = upc;
        upd_is_branch = br;
        upd_is_call   = call;
        upd_is_ret    = ret;
        upd_taken     = tk;
        upd_target    = tgt;
        step_no++;
        for (int m = 0; m < 2; m++) begin
            model_lookup(m, pc, et, ep);
            if (m == 0 && use_c) begin
                et = c_tk;
                ep = c_pc;
            end
            exp_q.push_back('{step: step_no, dut: m, taken: et, pc: ep});
        end
        look_en = 1'b1;
        if (!rst) begin
            model_update(0);
            model_update(1);
        end
    endtask

    task automatic look(input logic [31:0] pc, input bit c_tk, input logic [31:0] c_pc);
        step(1'b0, pc, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, c_tk, c_pc);
    endtask

    logic [31:0] pool [24];

    initial begin
        areset        = 1'b1;
        if_pc         = 32'h100;
        upd_valid     = 1'b0;
        upd_pc        = 32'd0;
        upd_is_branch = 1'b0;
        upd_is_call   = 1'b0;
        upd_is_ret    = 1'b0;
        upd_taken     = 1'b0;
        upd_target    = 32'd0;
        model_reset();
        for (int i = 0; i < 24; i++) begin
            pool[i] = ($urandom_range(0, 15) << 8) | ($urandom_range(0, 63) << 2);
        end
        pool[0] = 32'hFFFF_FFFC;

        // Reset held, with an update presented that must be ignored
        step(1, 32'h100, 1, 32'h40, 1, 0, 0, 1, 32'h80, 1, 0, 32'h104);
        step(1, 32'h100, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h104);
        // Branch training
        step(0, 32'h40, 1, 32'h40, 1, 0, 0, 1, 32'h80, 1, 0, 32'h44);
        look(32'h40, 1, 32'h80);
        look(32'h80, 0, 32'h84);
        step(0, 32'h40, 1, 32'h40, 1, 0, 0, 0, 32'h0, 1, 1, 32'h80);
        step(0, 32'h40, 1, 32'h40, 1, 0, 0, 0, 32'h0, 1, 0, 32'h44);
        look(32'h40, 0, 32'h44);
        for (int i = 0; i < 4; i++) step(0, 32'h40, 1, 32'h40, 1, 0, 0, 1, 32'h80);
        step(0, 32'h40, 1, 32'h40, 1, 0, 0, 0, 32'h0);
        look(32'h40, 1, 32'h80);
        // RAS
        step(0, 32'h0, 1, 32'h200, 0, 1, 0, 1, 32'h1000);
        step(0, 32'h0, 1, 32'h300, 0, 1, 0, 1, 32'h1000);
        step(0, 32'h0, 1, 32'h500, 0, 0, 1, 1, 32'h904);
        look(32'h500, 1, 32'h204);
        step(0, 32'h500, 1, 32'h500, 0, 0, 1, 1, 32'h904, 1, 1, 32'h204);
        look(32'h500, 1, 32'h904);
        // Overflow: prime a RET entry at index 1, then five calls and four pops
        step(0, 32'h0, 1, 32'h504, 0, 0, 1, 1, 32'h904);
        for (int i = 1; i <= 5; i++) step(0, 32'h0, 1, 32'h10 * i, 0, 1, 0, 1, 32'h2000);
        for (int i = 4; i >= 1; i--) begin
            step(0, 32'h504, 1, 32'h504, 0, 0, 1, 1, 32'h904, 1, 1, 32'h10 * (i + 1) + 32'h4);
        end
        look(32'h504, 1, 32'h904);
        // Simultaneous push and pop replaces the top without growing the stack
        step(0, 32'h0, 1, 32'h600, 0, 1, 0, 1, 32'h3000);
        step(0, 32'h0, 1, 32'h700, 0, 1, 1, 1, 32'h3000);
        step(0, 32'h504, 1, 32'h504, 0, 0, 1, 1, 32'h904, 1, 1, 32'h704);
        look(32'h504, 1, 32'h904);
        // Same-cycle hazard at index 3: old prediction now, new one next cycle
        step(0, 32'hC, 1, 32'hC, 1, 0, 0, 1, 32'h100, 1, 0, 32'h10);
        look(32'hC, 1, 32'h100);
        // Reset pulse mid-run, during an update
        step(1, 32'h100, 1, 32'hC, 1, 0, 0, 1, 32'h100, 1, 0, 32'h104);
        look(32'h40, 0, 32'h44);
        look(32'hC, 0, 32'h10);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            int unsigned r;
            bit          br;
            bit          call;
            bit          ret;
            bit          tk;
            r    = $urandom_range(0, 19);
            br   = (r < 10);
            call = (r >= 10 && r <= 13) || (r == 19);
            ret  = (r >= 14 && r <= 16) || (r == 19);
            tk   = br ? 1'($urandom_range(0, 1)) : 1'b1;
            step($urandom_range(0, 99) == 0, pool[$urandom_range(0, 23)],
                 $urandom_range(0, 9) < 7, pool[$urandom_range(0, 23)], br, call, ret, tk,
                 $urandom());
        end

        @(posedge aclk);
        look_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction unit for the five-stage RV32I pipeline. It combines an untagged saturating-counter BHT, a tagged BTB with per-entry type, and a return address stack (RAS). Lookup is combinational in IF; training comes from EX at branch/jump resolution. Entry count, counter width, tag width and RAS depth are configurable.

## Interface

- PC_WIDTH, 32, width of all PC/target buses
- ENTRIES, 16, BHT and BTB entries; power of 2, ≥2; IDX_BITS = log2(ENTRIES)
- CNT_BITS, 2, saturating counter width, ≥1
- TAG_BITS, 8, BTB tag width; IDX_BITS+TAG_BITS+2 ≤ PC_WIDTH
- RAS_DEPTH, 4, return stack entries, ≥1

Ports:

- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- if_pc  in  PC_WIDTH  fetch PC being looked up
- pred_taken  out  1  redirect fetch to pred_pc
- pred_pc  out  PC_WIDTH  predicted next PC
- upd_valid  in  1  EX has a resolved control-transfer instruction this cycle
- upd_pc  in  PC_WIDTH  PC of resolved instruction
- upd_is_branch  in  1  conditional branch
- upd_is_call  in  1  JAL/JALR with rd = x1/x5
- upd_is_ret  in  1  JALR with rs1 = x1/x5, rd ≠ rs1
- upd_taken  in  1  actual outcome (1 for all jumps)
- upd_target  in  PC_WIDTH  actual target

## Operation

- Index: pc[IDX_BITS+1:2]. Tag: pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- BTB entry: valid, tag, target, type ∈ {BRANCH, JUMP, RET}.
- hit = btb.valid[idx] && btb.tag[idx] == tag(if_pc).
- pred_taken = hit && (type != BRANCH || cnt[idx][CNT_BITS-1]).
- pred_pc: pred_taken and type == RET and RAS non-empty → RAS top. Otherwise pred_taken → BTB target. Otherwise → if_pc + 4, modulo 2^PC_WIDTH.
- BHT update when upd_valid && upd_is_branch, at index(upd_pc), no tag check:
  - taken → increment, saturating at 2^CNT_BITS−1
  - not taken → decrement, saturating at 0
- BTB write when upd_valid && upd_taken, at index(upd_pc): valid=1, tag, target=upd_target. Type = RET if upd_is_ret, else BRANCH if upd_is_branch, else JUMP.
- Not-taken branches never allocate or invalidate BTB entries.
- RAS is non-speculative. State: circular storage, top pointer, count 0..RAS_DEPTH.
  - Push (upd_valid && upd_is_call && !upd_is_ret): pointer advances and wraps; writes upd_pc+4; count saturates at RAS_DEPTH, so overflow overwrites the oldest entry.
  - Pop (upd_valid && upd_is_ret && !upd_is_call): count>0 → pointer retreats, count−1. count==0 → no change.
  - Both (upd_valid && upd_is_call && upd_is_ret): replace top with upd_pc+4; count unchanged, except 0 → 1.
- Control inputs are ignored when upd_valid=0.

## Timing

- Lookup: combinational, 0 cycles, no registers on the if_pc → pred_* path.
- Updates take effect at the aclk rising edge. They are visible to lookups from the next cycle.
- Update and lookup in the same cycle at the same index: the lookup sees pre-update state. No bypass.
- Reset, asserted asynchronously at any time, including mid-update:
  - all BTB valid bits = 0
  - all counters = 2^(CNT_BITS−1)−1 (weakly not-taken; 0 when CNT_BITS=1)
  - RAS count = 0, pointer = 0
- Targets need no reset.
- Outputs during and after reset: pred_taken=0, pred_pc=if_pc+4.
- Reset deassertion: the first update is accepted on the first rising edge with areset=0.

## Test plan

Defaults apply unless stated.

- **Reset:** areset pulse mid-run, if_pc=0x100 → pred_taken=0, pred_pc=0x104 immediately. Also while areset is held high.
- **Branch training:**
  - Update upd_pc=0x40, branch, taken, target 0x80 → next cycle if_pc=0x40 gives pred_taken=1, pred_pc=0x80.
  - Two not-taken updates → counter 0, pred_taken=0, pred_pc=0x44.
  - Three taken updates → counter saturates at 3.
- **Alias:** after training 0x40 → 0x80, lookup if_pc=0x80 (same index 0, tag 2 vs 1) → BTB miss, pred_taken=0, pred_pc=0x84.
- **RAS:**
  - Calls at 0x200 and 0x300, then return update upd_pc=0x500 target 0x904. The return's own pop leaves 0x204 on top, so if_pc=0x500 predicts 0x204.
  - Another return pop empties the RAS; if_pc=0x500 then predicts BTB target 0x904.
- **RAS overflow and simultaneous push/pop:**
  - Five calls at 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 → pops yield 0x54, 0x44, 0x34, 0x24, then empty.
  - Call+ret in one update → top replaced, count unchanged.
- **Same-cycle hazard:** taken update for index 3 while if_pc maps to index 3 → old prediction in that cycle, new prediction the following cycle. Rerun with ENTRIES=64, CNT_BITS=3, TAG_BITS=4.
